// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: FSM states and pc_sel redirect kinds.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        RUN        = 3'd1,
        MEM_WAIT   = 3'd2,
        REDIR_WAIT = 3'd3,
        HALTED     = 3'd4
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-unit controller: drives stall/pc_sel/flush/imem_req from memory readiness,
// execute-stage redirects, load-use hazards and halt/resume, plus two perf counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ready,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             load_use,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             clear_cnt,
    output logic             imem_req,
    output logic             stall,
    output logic [1:0]       pc_sel,
    output logic             flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    fetch_state_t state_q, state_d;
    logic [1:0]   kind_q, kind_d;
    logic [1:0]   sel_raw;
    logic         redir_evt;
    logic [1:0]   redir_kind;
    logic         stall_inc;
    logic         redir_inc;

    assign redir_evt  = jump | br_taken;
    assign redir_kind = jump ? PC_JUMP : PC_BRANCH;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            kind_q  <= PC_SEQ;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        imem_req = 1'b0;
        stall    = 1'b1;
        flush    = 1'b0;
        sel_raw  = PC_SEQ;
        case (state_q)
            BOOT: begin
                flush   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                if (halt_req) begin
                    flush   = 1'b1;
                    state_d = HALTED;
                end else if (redir_evt) begin
                    flush = 1'b1;
                    if (imem_ready) begin
                        stall   = 1'b0;
                        sel_raw = redir_kind;
                    end else begin
                        kind_d  = redir_kind;
                        state_d = REDIR_WAIT;
                    end
                end else if (load_use) begin
                    stall = 1'b1;
                end else if (!imem_ready) begin
                    state_d = MEM_WAIT;
                end else begin
                    stall = 1'b0;
                end
            end
            MEM_WAIT: begin
                imem_req = 1'b1;
                if (redir_evt) begin
                    flush = 1'b1;
                    if (imem_ready) begin
                        stall   = 1'b0;
                        sel_raw = redir_kind;
                        state_d = RUN;
                    end else begin
                        kind_d  = redir_kind;
                        state_d = REDIR_WAIT;
                    end
                end else if (imem_ready) begin
                    stall   = 1'b0;
                    state_d = RUN;
                end
            end
            // Execute-stage inputs here belong to the wrong path; only memory matters.
            REDIR_WAIT: begin
                imem_req = 1'b1;
                flush    = 1'b1;
                if (imem_ready) begin
                    stall   = 1'b0;
                    sel_raw = kind_q;
                    kind_d  = PC_SEQ;
                    state_d = RUN;
                end
            end
            HALTED: begin
                flush = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                flush   = 1'b1;
                state_d = BOOT;
            end
        endcase
    end

    assign pc_sel = stall ? PC_SEQ : sel_raw;
    assign state  = state_q;

    assign stall_inc = stall && (state_q != HALTED) && (state_q != BOOT);
    assign redir_inc = !stall && (pc_sel != PC_SEQ);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (clear_cnt),
        .q     (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redir_inc),
        .clr   (clear_cnt),
        .q     (redirect_count)
    );

endmodule
